// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run/reset/debug controller.
package cpu_run_pkg;

    // Command opcodes carried on cmd_op; 6 and 7 are accepted and ignored.
    localparam logic [2:0] OP_RUN      = 3'd0;
    localparam logic [2:0] OP_HALT     = 3'd1;
    localparam logic [2:0] OP_STEP     = 3'd2;
    localparam logic [2:0] OP_SET_BP   = 3'd3;
    localparam logic [2:0] OP_CLR_BP   = 3'd4;
    localparam logic [2:0] OP_SOFT_RST = 3'd5;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } run_state_e;

endpackage

// File: rtl/bp_match_unit.sv
// PC breakpoint slots: address/enable registers, parallel compare against
// the live PC and a lowest-index priority encoder.
module bp_match_unit #(
    parameter int NUM_BP = 4,
    parameter int PC_W   = 32,
    parameter int IDX_W  = 2
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_set,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [PC_W-1:0]   wr_addr,
    input  logic [PC_W-1:0]   pc,
    output logic              match,
    output logic [IDX_W-1:0]  idx
);

    logic [NUM_BP-1:0][PC_W-1:0] bp_addr;
    logic [NUM_BP-1:0]           bp_en;
    logic [NUM_BP-1:0]           hit;

    // Slot write/clear; an index with no matching slot falls through untouched.
    always_ff @(posedge clk_cpu) begin
        if (!reset) begin
            bp_en <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    bp_en[i] <= wr_set;
                    if (wr_set) bp_addr[i] <= wr_addr;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BP; g++) begin : g_slot
            assign hit[g] = bp_en[g] && (bp_addr[g] == pc);
        end
    endgenerate

    assign match = |hit;

    // Lowest matching slot wins: scan downward so the last hit written is the lowest.
    always_comb begin
        idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (hit[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/reset/debug controller for the CPU: sequenced reset hold, run/halt/step
// through a clock enable, PC breakpoints and a saturating executed-cycle count.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 10,
    parameter int NUM_BP     = 4,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter bit BOOT_RUN   = 1'b0
) (
    input  logic                                     clk_cpu,
    input  logic                                     reset,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [2:0]                               cmd_op,
    input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] cmd_idx,
    input  logic [PC_W-1:0]                          cmd_data,
    input  logic [PC_W-1:0]                          pc,
    output logic                                     cpu_rst,
    output logic                                     cpu_en,
    output logic                                     halted,
    output logic                                     bp_hit,
    output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_hit_idx,
    output logic [CNT_W-1:0]                         cycle_cnt
);
    import cpu_run_pkg::*;

    localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int HC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e       state, state_nxt;
    logic [HC_W-1:0]  hold_cnt;
    logic             skip, skip_nxt;
    logic             cmd_acc;
    logic             op_run, op_halt, op_step, op_set, op_clr, op_soft;
    logic             bp_match;
    logic [IDX_W-1:0] bp_idx;
    logic             bp_stop;
    logic             hit_clr;

    // cmd_ready is low exactly while in HOLD, so accepted commands never see HOLD.
    assign cmd_acc = cmd_valid && cmd_ready;
    assign op_run  = cmd_acc && (cmd_op == OP_RUN);
    assign op_halt = cmd_acc && (cmd_op == OP_HALT);
    assign op_step = cmd_acc && (cmd_op == OP_STEP);
    assign op_set  = cmd_acc && (cmd_op == OP_SET_BP);
    assign op_clr  = cmd_acc && (cmd_op == OP_CLR_BP);
    assign op_soft = cmd_acc && (cmd_op == OP_SOFT_RST);

    bp_match_unit #(
        .NUM_BP (NUM_BP),
        .PC_W   (PC_W),
        .IDX_W  (IDX_W)
    ) u_bp (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .wr_en   (op_set || op_clr),
        .wr_set  (op_set),
        .wr_idx  (cmd_idx),
        .wr_addr (cmd_data),
        .pc      (pc),
        .match   (bp_match),
        .idx     (bp_idx)
    );

    // Next state, clock enable and breakpoint-stop decode.
    always_comb begin
        state_nxt = state;
        cpu_en    = 1'b0;
        skip_nxt  = 1'b0;
        bp_stop   = 1'b0;
        hit_clr   = 1'b0;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HC_W'(RST_CYCLES - 1))
                    state_nxt = BOOT_RUN ? ST_RUN : ST_HALTED;
            end
            ST_HALTED: begin
                if (op_soft) begin
                    state_nxt = ST_HOLD;
                end else if (op_run) begin
                    state_nxt = ST_RUN;
                    skip_nxt  = 1'b1;
                    hit_clr   = 1'b1;
                end else if (op_step) begin
                    state_nxt = ST_STEP;
                    hit_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                // skip lets execution resume from the address it stopped on
                cpu_en  = !bp_match || skip;
                bp_stop = bp_match && !skip;
                if (op_soft)
                    state_nxt = ST_HOLD;
                else if (bp_stop || op_halt)
                    state_nxt = ST_HALTED;
            end
            ST_STEP: begin
                cpu_en    = 1'b1;
                state_nxt = op_soft ? ST_HOLD : ST_HALTED;
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    // State, hold counter, sticky hit flag, cycle counter and registered outputs.
    always_ff @(posedge clk_cpu) begin
        if (!reset) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            skip       <= 1'b0;
            bp_hit     <= 1'b0;
            bp_hit_idx <= '0;
            cycle_cnt  <= '0;
            cpu_rst    <= 1'b1;
            cmd_ready  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip     <= skip_nxt;
            hold_cnt <= (state == ST_HOLD && state_nxt == ST_HOLD) ? hold_cnt + HC_W'(1) : '0;

            if (op_soft) begin
                bp_hit <= 1'b0;
            end else if (bp_stop) begin
                bp_hit     <= 1'b1;
                bp_hit_idx <= bp_idx;
            end else if (hit_clr) begin
                bp_hit <= 1'b0;
            end

            if (op_soft)
                cycle_cnt <= '0;
            else if (cpu_en && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + CNT_W'(1);

            cpu_rst   <= (state_nxt == ST_HOLD);
            cmd_ready <= (state_nxt != ST_HOLD);
            halted    <= (state_nxt == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random commands, with a
// cycle-by-cycle behavioural model for instance A and literal checks for B.
module tb_cpu_run_ctrl;

    localparam int  RA  = 10;
    localparam int  NBA = 3;
    localparam longint CMAX_A = 64'hFFFF_FFFF;

    localparam int M_HOLD = 0, M_HALTED = 1, M_RUN = 2, M_STEP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: model-checked ----------------
    logic        reset_a, cmd_valid_a, cmd_ready_a;
    logic [2:0]  cmd_op_a;
    logic [1:0]  cmd_idx_a, bp_hit_idx_a;
    logic [31:0] cmd_data_a, pc_a, cycle_cnt_a;
    logic        cpu_rst_a, cpu_en_a, halted_a, bp_hit_a;

    cpu_run_ctrl #(.RST_CYCLES(RA), .NUM_BP(NBA), .PC_W(32), .CNT_W(32), .BOOT_RUN(1'b0)) dut_a (
        .clk_cpu(clk), .reset(reset_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_op(cmd_op_a), .cmd_idx(cmd_idx_a), .cmd_data(cmd_data_a), .pc(pc_a),
        .cpu_rst(cpu_rst_a), .cpu_en(cpu_en_a), .halted(halted_a), .bp_hit(bp_hit_a),
        .bp_hit_idx(bp_hit_idx_a), .cycle_cnt(cycle_cnt_a));

    // ---------------- instance B: boot-to-run, narrow counter ----------------
    logic        reset_b, cmd_valid_b, cmd_ready_b;
    logic [2:0]  cmd_op_b;
    logic [1:0]  cmd_idx_b, bp_hit_idx_b;
    logic [15:0] cmd_data_b, pc_b;
    logic [3:0]  cycle_cnt_b;
    logic        cpu_rst_b, cpu_en_b, halted_b, bp_hit_b;

    cpu_run_ctrl #(.RST_CYCLES(2), .NUM_BP(4), .PC_W(16), .CNT_W(4), .BOOT_RUN(1'b1)) dut_b (
        .clk_cpu(clk), .reset(reset_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_op(cmd_op_b), .cmd_idx(cmd_idx_b), .cmd_data(cmd_data_b), .pc(pc_b),
        .cpu_rst(cpu_rst_b), .cpu_en(cpu_en_b), .halted(halted_b), .bp_hit(bp_hit_b),
        .bp_hit_idx(bp_hit_idx_b), .cycle_cnt(cycle_cnt_b));

    // ---------------- behavioural model of A ----------------
    bit          m_known = 0;
    int          m_mode, m_hold_left, m_hit_idx;
    logic [31:0] m_addr [NBA];
    bit          m_on [NBA];
    bit          m_skip, m_hit;
    longint      m_cnt;
    int          cmp_mi;
    bit          cmp_en, cmp_acc;

    function automatic int m_first_match(input logic [31:0] p);
        for (int i = 0; i < NBA; i++)
            if (m_on[i] && m_addr[i] == p) return i;
        return -1;
    endfunction

    // Compare on the falling edge, then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        cmp_mi = m_first_match(pc_a);
        cmp_en = (m_mode == M_STEP) || (m_mode == M_RUN && (cmp_mi < 0 || m_skip));
        if (m_known) begin
            chk("cpu_rst",    cpu_rst_a,    m_mode == M_HOLD);
            chk("cmd_ready",  cmd_ready_a,  m_mode != M_HOLD);
            chk("halted",     halted_a,     m_mode == M_HALTED);
            chk("cpu_en",     cpu_en_a,     cmp_en);
            chk("bp_hit",     bp_hit_a,     m_hit);
            chk("bp_hit_idx", bp_hit_idx_a, m_hit_idx);
            chk("cycle_cnt",  cycle_cnt_a,  m_cnt);
        end
        if (!reset_a) begin
            m_known = 1; m_mode = M_HOLD; m_hold_left = RA;
            m_skip = 0; m_hit = 0; m_hit_idx = 0; m_cnt = 0;
            for (int i = 0; i < NBA; i++) m_on[i] = 0;
        end else if (m_known) begin
            if (m_mode == M_HOLD) begin
                if (m_hold_left <= 1) m_mode = M_HALTED;
                else m_hold_left--;
            end else begin
                cmp_acc = cmd_valid_a;
                if (cmp_acc && cmd_op_a == 3'd5) begin
                    m_mode = M_HOLD; m_hold_left = RA; m_cnt = 0; m_hit = 0; m_skip = 0;
                end else begin
                    if (cmp_en && m_cnt < CMAX_A) m_cnt++;
                    if (cmp_acc && cmd_op_a == 3'd3 && cmd_idx_a < NBA) begin
                        m_addr[cmd_idx_a] = cmd_data_a; m_on[cmd_idx_a] = 1;
                    end
                    if (cmp_acc && cmd_op_a == 3'd4 && cmd_idx_a < NBA) m_on[cmd_idx_a] = 0;
                    case (m_mode)
                        M_RUN: begin
                            if (cmp_mi >= 0 && !m_skip) begin
                                m_hit = 1; m_hit_idx = cmp_mi; m_mode = M_HALTED;
                            end else if (cmp_acc && cmd_op_a == 3'd1) begin
                                m_mode = M_HALTED;
                            end
                            m_skip = 0;
                        end
                        M_HALTED: begin
                            if (cmp_acc && cmd_op_a == 3'd0) begin
                                m_mode = M_RUN; m_skip = 1; m_hit = 0;
                            end else if (cmp_acc && cmd_op_a == 3'd2) begin
                                m_mode = M_STEP; m_hit = 0;
                            end
                        end
                        default: m_mode = M_HALTED;
                    endcase
                end
            end
        end
    end

    // ---------------- stimulus helpers for A ----------------
    int n_en = 0;
    bit wrap = 0;
    bit last_rst;
    bit b_done = 0;

    // One clock: sample en/rst before the edge, then behave like the CPU's PC register.
    task automatic tick();
        bit en_s;
        @(negedge clk);
        en_s     = cpu_en_a;
        last_rst = cpu_rst_a;
        @(posedge clk);
        #1;
        if (en_s) begin
            n_en++;
            pc_a = wrap ? ((pc_a + 32'd4) & 32'h3F) : pc_a + 32'd4;
        end
        cmd_valid_a = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] idx, input logic [31:0] d);
        cmd_valid_a = 1'b1; cmd_op_a = op; cmd_idx_a = idx; cmd_data_a = d;
        tick();
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n;
        n = 0;
        while (!halted_a && n < budget) begin tick(); n++; end
        chk(name, halted_a, 1'b1);
    endtask

    task automatic count_rst(input string name);
        int c;
        c = 0;
        repeat (15) begin tick(); if (last_rst) c++; end
        chk(name, c, RA);
    endtask

    initial begin
        int n, n0;
        reset_a = 1'b0; cmd_valid_a = 1'b0; cmd_op_a = '0; cmd_idx_a = '0;
        cmd_data_a = '0; pc_a = '0;

        // reset held 3 cycles, then the hold length and halted landing
        repeat (3) tick();
        chk("rst_state_rst", cpu_rst_a, 1'b1);
        chk("rst_state_rdy", cmd_ready_a, 1'b0);
        reset_a = 1'b1;
        count_rst("hold_len");
        chk("boot_halted", halted_a, 1'b1);
        chk("boot_en", cpu_en_a, 1'b0);
        chk("boot_ready", cmd_ready_a, 1'b1);

        // breakpoint at 0x40 in slot 1
        pc_a = 32'h30;
        cmd(3'd3, 2'd1, 32'h40);
        cmd(3'd0, 2'd0, 32'h0);
        wait_halt("bp1_halt", 30);
        chk("bp1_pc", pc_a, 32'h40);
        chk("bp1_hit", bp_hit_a, 1'b1);
        chk("bp1_idx", bp_hit_idx_a, 2'd1);
        chk("bp1_cnt", cycle_cnt_a, 32'd4);

        // resume over the breakpoint, then halt
        cmd(3'd0, 2'd0, 32'h0);
        chk("skip_en", cpu_en_a, 1'b1);
        chk("skip_pc", pc_a, 32'h40);
        tick(); tick();
        cmd(3'd1, 2'd0, 32'h0);
        chk("halt_state", halted_a, 1'b1);
        chk("halt_cnt", cycle_cnt_a, 32'd7);
        chk("halt_pc", pc_a, 32'h4C);

        // three single steps
        n0 = n_en;
        repeat (3) begin cmd(3'd2, 2'd0, 32'h0); tick(); end
        chk("step_pulses", n_en - n0, 3);
        chk("step_cnt", cycle_cnt_a, 32'd10);
        chk("step_pc", pc_a, 32'h58);

        // two slots on 0x80: lowest wins, then slot 2 after clearing slot 0
        cmd(3'd3, 2'd0, 32'h80);
        cmd(3'd3, 2'd2, 32'h80);
        cmd(3'd0, 2'd0, 32'h0);
        wait_halt("dual_halt", 40);
        chk("dual_pc", pc_a, 32'h80);
        chk("dual_idx", bp_hit_idx_a, 2'd0);
        cmd(3'd4, 2'd0, 32'h0);
        pc_a = 32'h7C;
        cmd(3'd0, 2'd0, 32'h0);
        wait_halt("clr_halt", 20);
        chk("clr_pc", pc_a, 32'h80);
        chk("clr_idx", bp_hit_idx_a, 2'd2);
        chk("clr_cnt", cycle_cnt_a, 32'd21);

        // soft reset mid-run at cycle_cnt=25
        cmd(3'd0, 2'd0, 32'h0);
        n = 0;
        while (cycle_cnt_a != 32'd25 && n < 50) begin tick(); n++; end
        chk("cnt_25", cycle_cnt_a, 32'd25);
        cmd(3'd5, 2'd0, 32'h0);
        chk("soft_rst", cpu_rst_a, 1'b1);
        chk("soft_rdy", cmd_ready_a, 1'b0);
        chk("soft_cnt", cycle_cnt_a, 32'd0);
        chk("soft_hit", bp_hit_a, 1'b0);
        count_rst("soft_hold_len");
        chk("soft_halted", halted_a, 1'b1);
        pc_a = 32'h7C;
        cmd(3'd0, 2'd0, 32'h0);
        wait_halt("kept_halt", 20);
        chk("kept_pc", pc_a, 32'h80);
        chk("kept_idx", bp_hit_idx_a, 2'd2);

        // index beyond the last slot must not create a breakpoint
        cmd(3'd3, 2'd3, 32'hA0);
        pc_a = 32'h90;
        cmd(3'd0, 2'd0, 32'h0);
        repeat (10) tick();
        cmd(3'd1, 2'd0, 32'h0);
        chk("oob_halted", halted_a, 1'b1);
        chk("oob_hit", bp_hit_a, 1'b0);
        chk("oob_pc", pc_a, 32'hBC);

        // random commands over a small PC window so breakpoints hit often
        wrap = 1'b1;
        pc_a = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid_a = 1'b1;
                cmd_op_a    = 3'($urandom_range(0, 7));
                if (cmd_op_a == 3'd5 && $urandom_range(0, 7) != 0) cmd_op_a = 3'd1;
                cmd_idx_a   = 2'($urandom_range(0, 3));
                cmd_data_a  = 32'($urandom_range(0, 15)) << 2;
            end
            if (halted_a && $urandom_range(0, 3) == 0) pc_a = 32'($urandom_range(0, 15)) << 2;
            if (i == 300) reset_a = 1'b0;
            if (i == 302) reset_a = 1'b1;
            tick();
        end

        n = 0;
        while (!b_done && n < 200) begin tick(); n++; end
        chk("b_done", b_done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Instance B: boot straight into RUN, 4-bit counter saturates.
    initial begin
        int first;
        reset_b = 1'b0; cmd_valid_b = 1'b0; cmd_op_b = '0; cmd_idx_b = '0;
        cmd_data_b = '0; pc_b = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_b = 1'b1;
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            @(negedge clk);
            if (cpu_en_b) first = i;
        end
        chk("b_first_en", first, 3);
        repeat (20) @(posedge clk);
        #2;
        chk("b_cnt_sat", cycle_cnt_b, 4'd15);
        chk("b_running", halted_b, 1'b0);
        chk("b_rst_low", cpu_rst_b, 1'b0);
        b_done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
